// File: rtl/serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg
// Shared types and helpers for the bit-serial adder/subtractor.
//   state_e      : controller state encoding
//   width_legal  : true when an operand width is supported by the datapath
// ---------------------------------------------------------------------------
package serial_addsub_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// ---------------------------------------------------------------------------
// fa_cell
// Single-bit combinational full adder; the only arithmetic element of the
// serial datapath.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// ---------------------------------------------------------------------------
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock
// through a single full-adder cell, behind a start/busy/done handshake.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : operation request, sampled in IDLE only
//   sub       : 0 = a+b, 1 = a-b (sampled with start)
//   a, b      : WIDTH-bit operands (sampled with start)
//   busy      : high during the WIDTH RUN cycles
//   done      : one-cycle pulse, result and flags valid
//   sum       : result register
//   carry     : carry out of MSB (subtraction: 1 = no borrow)
//   overflow  : signed overflow
//   zero      : sum == 0
//   negative  : sum MSB
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched when it arrives
// RUN   | one bit per cycle through fa_cell, WIDTH cycles
// DONE  | result/flags just registered; done pulse; back to IDLE
// ---------------------------------------------------------------------------
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("serial_addsub: WIDTH must be in 2..32");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  // Only WIDTH-1 sum bits need storing: the MSB comes straight from the
  // adder in the final RUN cycle.
  logic [WIDTH-2:0]   acc_q, acc_d;
  logic               cy_q, cy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-2:0]   acc_shift;
  logic [WIDTH-1:0]   result_full;
  logic               last_bit;

  fa_cell u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (cy_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  if (WIDTH > 2) begin : g_acc_wide
    assign acc_shift = {fa_s, acc_q[WIDTH-2:1]};
  end else begin : g_acc_narrow
    assign acc_shift = fa_s;
  end

  assign result_full = {fa_s, acc_q};
  assign last_bit    = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          // Subtraction is a + ~b + 1: invert b here, the +1 is the initial carry.
          opb_d   = sub ? ~b : b;
          cy_d    = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d = acc_shift;
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        cy_d  = fa_cout;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = DONE;
          sum_d   = result_full;
          carry_d = fa_cout;
          // cy_q here is the carry into the MSB column.
          ovf_d   = cy_q ^ fa_cout;
          zero_d  = (result_full == '0);
          neg_d   = fa_s;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised, bit-serial two's-complement adder/subtractor. It is the sequential successor to the fixed 8-bit constant-sum block: it takes two WIDTH-bit operands, computes A+B or A−B one bit per clock (LSB first) through a single full-adder cell, and reports result, carry, overflow, zero and negative flags. It sits behind a start/busy/done handshake so a controller can issue operations back to back.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
sub  in  1  0 = A+B, 1 = A−B; sampled with start
a  in  WIDTH  operand A, two's complement; sampled with start
b  in  WIDTH  operand B, two's complement; sampled with start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; result valid
sum  out  WIDTH  result register
carry  out  1  carry out of MSB (for subtraction, 1 = no borrow)
overflow  out  1  signed overflow
zero  out  1  sum == 0
negative  out  1  sum[WIDTH-1]

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, sum, carry, overflow, zero, negative all 0; internal shift registers, counter and carry flop all 0. Reset mid-RUN aborts the operation and produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch opA = a and opB = (sub ? ~b : b), set carry flop = sub, set count = 0, and go to RUN. start=0 keeps the block in IDLE.
- RUN (busy=1): each cycle, the full-adder cell adds opA[0] + opB[0] + carry flop.
  - The sum bit shifts into the MSB of the result shift register (right shift). opA and opB shift right. The carry flop is updated. count increments.
  - When count == WIDTH-1 is processed, capture the carry into the MSB (cin_msb) before the final update.
  - After exactly WIDTH RUN cycles, go to DONE.
- Entering DONE: write sum = shift register; carry = final carry out; overflow = cin_msb XOR final carry out; zero = (sum == 0); negative = sum MSB.
- DONE: done = 1 for exactly one cycle, then return to IDLE unconditionally.
- Latency: start high in cycle t → busy high in cycles t+1..t+WIDTH → done high in cycle t+WIDTH+1.
- Result and flag outputs change only on entry to DONE and hold until the next DONE or reset. They do not ripple during RUN.
- start is ignored in RUN and DONE; it is neither queued nor an error. The earliest next start is accepted in the cycle after done, giving a throughput of one operation per WIDTH+2 cycles.
- Changes to a, b or sub after the start cycle have no effect on the current operation.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- Boundary cases:
  - −2^(W−1) − 1 overflows.
  - 0 − 0 gives carry = 1 and zero = 1.
  - −2^(W−1) + −2^(W−1) gives sum 0, carry 1, overflow 1.

Decomposition:
- Package serial_addsub_pkg: state enum (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and a function for the WIDTH legality check.
- Sub-module fa_cell (a, b, cin → s, cout): a combinational full adder, instantiated once.
- Top level: FSM, counter, shift registers and flag logic.

Test Plan:
1. WIDTH=8; a=−100 (0x9C), b=53 (0x35), sub=0, start pulse → done at t+9; sum=0xD1 (−47), carry=0, overflow=0, negative=1, zero=0; busy high for exactly 8 cycles.
2. WIDTH=8; a=100, b=53, sub=0 → sum=0x99, overflow=1, negative=1, carry=0.
3. WIDTH=8; a=0x80, b=0x01, sub=1 → sum=0x7F, overflow=1, carry=1, negative=0. Then a=5, b=5, sub=1 → sum=0x00, zero=1, carry=1, overflow=0.
4. start held high continuously, with a/b changed every cycle during RUN → only the first operands are used; exactly one done per WIDTH+2 cycles; sum stays stable between done pulses.
5. rst_n driven low in the 4th RUN cycle → all outputs 0 immediately (asynchronously); no done pulse. After release, a new start yields a correct result.
6. WIDTH=16; a=0x7FFF, b=0x0001, sub=0 → done at t+17; sum=0x8000, overflow=1. Also a=−1, b=−1 → sum=0xFFFE, carry=1, overflow=0.
